// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and MDU results.
// Tracks pending MDU destinations and forces MDU retirement after STARVE_MAX lost cycles.
module rf_wb_arbiter #(
  parameter int BUF_DEPTH  = 2,
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  output logic        iss_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  rd_a,
  input  logic [4:0]  rd_b,
  output logic        hazard,
  output logic        rf_w_en,
  output logic [4:0]  rf_req_w,
  output logic [31:0] rf_data_w
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_OUT_C    = CW'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);
  localparam logic [PW:0]   PTR_ONE_C    = {{PW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] STV_ONE_C    = {{(SW-1){1'b0}}, 1'b1};

  logic [4:0]    fifo_reg_r  [BUF_DEPTH];
  logic [31:0]   fifo_data_r [BUF_DEPTH];
  logic [PW:0]   wr_ptr_r, rd_ptr_r;
  logic [31:0]   busy_r, busy_nxt_s, clr_mask_s, set_mask_s;
  logic [CW-1:0] out_cnt_r;
  logic [SW-1:0] starve_r, starve_nxt_s;
  logic          active_s, empty_s, full_s;
  logic [4:0]    head_reg_s;
  logic [31:0]   head_data_s;
  logic          iss_ready_s, mdu_ready_s, wb_stall_s, force_mdu_s;
  logic          grant_wb_s, grant_mdu_s, iss_fire_s, mdu_fire_s;
  logic          rf_w_en_s;
  logic [4:0]    rf_req_w_s;
  logic [31:0]   rf_data_w_s;

  assign active_s    = rst_n & en;
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign head_reg_s  = fifo_reg_r[rd_ptr_r[PW-1:0]];
  assign head_data_s = fifo_data_r[rd_ptr_r[PW-1:0]];
  assign iss_fire_s  = iss_valid & iss_ready_s;
  assign mdu_fire_s  = mdu_valid & mdu_ready_s;

  // Handshake readiness and write-port grant; starvation overrides writeback
  always_comb begin
    iss_ready_s = 1'b0;
    mdu_ready_s = 1'b0;
    wb_stall_s  = 1'b1;
    force_mdu_s = 1'b0;
    grant_wb_s  = 1'b0;
    grant_mdu_s = 1'b0;
    if (active_s) begin
      iss_ready_s = ((iss_reg == 5'd0) || !busy_r[iss_reg]) && (out_cnt_r < MAX_OUT_C);
      mdu_ready_s = !full_s;
      force_mdu_s = (starve_r == STARVE_MAX_C) && !empty_s;
      wb_stall_s  = force_mdu_s;
      if (force_mdu_s) begin
        grant_mdu_s = 1'b1;
      end else if (wb_valid) begin
        grant_wb_s = 1'b1;
      end else if (!empty_s) begin
        grant_mdu_s = 1'b1;
      end else begin
        grant_mdu_s = 1'b0;
      end
    end else begin
      wb_stall_s = 1'b1;
    end
  end

  // Write-port mux; writes to r0 are suppressed
  always_comb begin
    rf_req_w_s  = 5'd0;
    rf_data_w_s = 32'd0;
    if (grant_mdu_s) begin
      rf_req_w_s  = head_reg_s;
      rf_data_w_s = head_data_s;
    end else if (grant_wb_s) begin
      rf_req_w_s  = wb_reg;
      rf_data_w_s = wb_data;
    end else begin
      rf_req_w_s  = 5'd0;
      rf_data_w_s = 32'd0;
    end
    rf_w_en_s = (grant_mdu_s | grant_wb_s) & (rf_req_w_s != 5'd0);
  end

  // Scoreboard and starvation next-state
  always_comb begin
    clr_mask_s = grant_mdu_s ? (32'd1 << head_reg_s) : 32'd0;
    set_mask_s = iss_fire_s ? (32'd1 << iss_reg) : 32'd0;
    busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
    if (empty_s || grant_mdu_s) begin
      starve_nxt_s = '0;
    end else if (starve_r == STARVE_MAX_C) begin
      starve_nxt_s = starve_r;
    end else begin
      starve_nxt_s = starve_r + STV_ONE_C;
    end
  end

  // Control state: pointers, scoreboard, outstanding count, starvation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      busy_r    <= 32'd0;
      out_cnt_r <= '0;
      starve_r  <= '0;
    end else if (en) begin
      if (mdu_fire_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (grant_mdu_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      busy_r   <= busy_nxt_s;
      starve_r <= starve_nxt_s;
      case ({iss_fire_s, grant_mdu_s})
        2'b10:   out_cnt_r <= out_cnt_r + CNT_ONE_C;
        2'b01:   out_cnt_r <= out_cnt_r - CNT_ONE_C;
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // Result storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (mdu_fire_s) begin
      fifo_reg_r[wr_ptr_r[PW-1:0]]  <= mdu_reg;
      fifo_data_r[wr_ptr_r[PW-1:0]] <= mdu_data;
    end
  end

  assign iss_ready = iss_ready_s;
  assign mdu_ready = mdu_ready_s;
  assign wb_stall  = wb_stall_s;
  assign hazard    = ((rd_a != 5'd0) && busy_r[rd_a]) || ((rd_b != 5'd0) && busy_r[rd_b]);
  assign rf_w_en   = rf_w_en_s;
  assign rf_req_w  = rf_req_w_s;
  assign rf_data_w = rf_data_w_s;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int BUF_DEPTH  = 2;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic wb_valid = 1'b0, iss_valid = 1'b0, mdu_valid = 1'b0;
  logic [4:0] wb_reg = 5'd0, iss_reg = 5'd0, mdu_reg = 5'd0, rd_a = 5'd0, rd_b = 5'd0;
  logic [31:0] wb_data = 32'd0, mdu_data = 32'd0;
  logic wb_stall, iss_ready, mdu_ready, hazard, rf_w_en;
  logic [4:0] rf_req_w;
  logic [31:0] rf_data_w;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.BUF_DEPTH(BUF_DEPTH), .MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rd_a(rd_a), .rd_b(rd_b), .hazard(hazard),
    .rf_w_en(rf_w_en), .rf_req_w(rf_req_w), .rf_data_w(rf_data_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: result queue, busy set, outstanding ops, lost-arbitration count
  logic [4:0]  m_qreg[$];
  logic [31:0] m_qdata[$];
  bit [31:0]   m_busy = 32'd0;
  int          m_out = 0;
  int          m_starve = 0;
  bit          chk_on = 1'b0;
  bit          m_iss_fire = 1'b0, m_mdu_fire = 1'b0;
  logic [4:0]  log_q[$];

  // Model evaluation and output comparison, once per cycle mid-period
  always @(negedge clk) begin
    if (chk_on) begin
      bit e_iss, e_mdu, e_stall, g_wb, g_mdu, e_wen, e_haz;
      logic [4:0] e_req;
      logic [31:0] e_data;
      int nst;
      e_iss = 1'b0; e_mdu = 1'b0; e_stall = 1'b1; g_wb = 1'b0; g_mdu = 1'b0;
      e_req = 5'd0; e_data = 32'd0;
      e_haz = (rd_a != 5'd0 && m_busy[rd_a]) || (rd_b != 5'd0 && m_busy[rd_b]);
      if (rst_n && en) begin
        e_iss = (iss_reg == 5'd0 || !m_busy[iss_reg]) && (m_out < MAX_OUT);
        e_mdu = m_qreg.size() < BUF_DEPTH;
        if (m_starve == STARVE_MAX && m_qreg.size() > 0) begin
          g_mdu = 1'b1; e_stall = 1'b1;
        end else begin
          e_stall = 1'b0;
          if (wb_valid) g_wb = 1'b1;
          else if (m_qreg.size() > 0) g_mdu = 1'b1;
        end
      end
      if (g_mdu) begin e_req = m_qreg[0]; e_data = m_qdata[0]; end
      if (g_wb) begin e_req = wb_reg; e_data = wb_data; end
      e_wen = (g_mdu || g_wb) && e_req != 5'd0;
      chk("iss_ready", iss_ready, e_iss);
      chk("mdu_ready", mdu_ready, e_mdu);
      chk("wb_stall", wb_stall, e_stall);
      chk("hazard", hazard, e_haz);
      chk("rf_w_en", rf_w_en, e_wen);
      if (e_wen) begin
        chk("rf_req_w", rf_req_w, e_req);
        chk("rf_data_w", rf_data_w, e_data);
      end
      if (rf_w_en === 1'b1 && rf_req_w >= 5'd1 && rf_req_w <= 5'd3) log_q.push_back(rf_req_w);
      m_iss_fire = e_iss && iss_valid;
      m_mdu_fire = e_mdu && mdu_valid;
      if (!rst_n) begin
        m_qreg.delete(); m_qdata.delete(); m_busy = 32'd0; m_out = 0; m_starve = 0;
      end else if (en) begin
        if (m_qreg.size() == 0 || g_mdu) nst = 0;
        else nst = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        if (g_mdu) begin
          m_busy[m_qreg[0]] = 1'b0;
          void'(m_qreg.pop_front()); void'(m_qdata.pop_front());
          m_out--;
        end
        if (m_iss_fire) begin
          if (iss_reg != 5'd0) m_busy[iss_reg] = 1'b1;
          m_out++;
        end
        if (m_mdu_fire) begin m_qreg.push_back(mdu_reg); m_qdata.push_back(mdu_data); end
        m_starve = nst;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r);
    bit done;
    done = 1'b0;
    iss_valid = 1'b1; iss_reg = r;
    for (int k = 0; k < 20 && !done; k++) begin
      #1; done = iss_ready; step();
    end
    iss_valid = 1'b0;
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic result(input logic [4:0] r, input logic [31:0] d);
    bit done;
    done = 1'b0;
    mdu_valid = 1'b1; mdu_reg = r; mdu_data = d;
    for (int k = 0; k < 20 && !done; k++) begin
      #1; done = mdu_ready; step();
    end
    mdu_valid = 1'b0;
    if (!done) chk("result_timeout", 32'd0, 32'd1);
  endtask

  logic [4:0] p_q[$];
  bit last_rst;

  initial begin
    step();
    chk_on = 1'b1;
    step();
    #1;
    chk("reset_iss_ready", iss_ready, 32'd0);
    chk("reset_wb_stall", wb_stall, 32'd1);
    rst_n = 1'b1; en = 1'b1;
    step();

    // single issue and result, hazard lifetime
    iss_valid = 1'b1; iss_reg = 5'd5; rd_a = 5'd5; #1;
    chk("t1_iss_ready", iss_ready, 32'd1);
    chk("t1_haz_before", hazard, 32'd0);
    step();
    iss_valid = 1'b0; mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'hDEAD; #1;
    chk("t1_haz_busy", hazard, 32'd1);
    chk("t1_no_bypass", rf_w_en, 32'd0);
    step();
    mdu_valid = 1'b0; #1;
    chk("t1_wen", rf_w_en, 32'd1);
    chk("t1_req", rf_req_w, 32'd5);
    chk("t1_data", rf_data_w, 32'hDEAD);
    chk("t1_haz_during_write", hazard, 32'd1);
    step(); #1;
    chk("t1_haz_cleared", hazard, 32'd0);
    rd_a = 5'd0;

    // anti-starvation with writeback held every cycle
    issue(5'd7);
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h77;
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
    step();
    mdu_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_wb_wins", wb_stall, 32'd0);
      chk("t2_wb_req", rf_req_w, 32'd9);
      step();
    end
    #1;
    chk("t2_forced_stall", wb_stall, 32'd1);
    chk("t2_forced_req", rf_req_w, 32'd7);
    chk("t2_forced_data", rf_data_w, 32'h77);
    step(); #1;
    chk("t2_starve_reset", wb_stall, 32'd0);
    step();
    wb_valid = 1'b0;

    // FIFO full under saturated writeback
    issue(5'd1); issue(5'd2); issue(5'd3);
    log_q.delete();
    wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'hA0;
    result(5'd1, 32'h11);
    result(5'd2, 32'h22);
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h33; #1;
    chk("t3_full_ready", mdu_ready, 32'd0);
    result(5'd3, 32'h33);
    for (int c = 0; c < 14; c++) step();
    wb_valid = 1'b0;
    step(); step();
    chk("t3_write_count", log_q.size(), 32'd3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) chk("t3_order", log_q[k], k + 1);

    // outstanding limit
    issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
    iss_valid = 1'b1; iss_reg = 5'd6;
    mdu_valid = 1'b1; mdu_reg = 5'd1; mdu_data = 32'h1; #1;
    chk("t4_limit", iss_ready, 32'd0);
    step();
    mdu_valid = 1'b0; #1;
    chk("t4_retire_cycle_ready", iss_ready, 32'd0);
    chk("t4_retire_req", rf_req_w, 32'd1);
    step(); #1;
    chk("t4_accept_after_retire", iss_ready, 32'd1);
    step();
    iss_valid = 1'b0;
    result(5'd2, 32'h2); result(5'd3, 32'h3); result(5'd4, 32'h4); result(5'd6, 32'h6);
    for (int c = 0; c < 4; c++) step();

    // r0 issue and result: no write, no hazard, count still returns
    issue(5'd0);
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h1;
    step();
    mdu_valid = 1'b0; #1;
    chk("t5_r0_no_write", rf_w_en, 32'd0);
    chk("t5_r0_no_hazard", hazard, 32'd0);
    step();
    issue(5'd8); issue(5'd9); issue(5'd10); issue(5'd11);
    result(5'd8, 32'h8); result(5'd9, 32'h9); result(5'd10, 32'hA); result(5'd11, 32'hB);
    for (int c = 0; c < 4; c++) step();

    // freeze with a buffered result, then resume
    issue(5'd3);
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h33;
    wb_valid = 1'b1; wb_reg = 5'd12; wb_data = 32'hC;
    step();
    mdu_valid = 1'b0;
    step();
    en = 1'b0; rd_a = 5'd3;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t6_frozen_wen", rf_w_en, 32'd0);
      chk("t6_frozen_stall", wb_stall, 32'd1);
      chk("t6_frozen_hazard", hazard, 32'd1);
      step();
    end
    en = 1'b1; #1;
    chk("t6_resume_s1", wb_stall, 32'd0);
    step(); #1;
    chk("t6_resume_s2", wb_stall, 32'd0);
    step(); #1;
    chk("t6_resume_forced", wb_stall, 32'd1);
    chk("t6_resume_req", rf_req_w, 32'd3);
    step();

    // reset mid-operation discards buffered result and busy bits
    issue(5'd3);
    mdu_valid = 1'b1; mdu_reg = 5'd3; mdu_data = 32'h34;
    step();
    mdu_valid = 1'b0; en = 1'b0;
    step();
    rst_n = 1'b0; en = 1'b1; #1;
    chk("t6_rst_wen", rf_w_en, 32'd0);
    chk("t6_rst_mdu_ready", mdu_ready, 32'd0);
    step();
    rst_n = 1'b1; wb_valid = 1'b0; #1;
    chk("t6_rst_hazard", hazard, 32'd0);
    chk("t6_rst_fifo_empty", rf_w_en, 32'd0);
    step();
    rd_a = 5'd0;
    step();

    // random traffic against the model
    last_rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (last_rst) begin
        p_q.delete(); mdu_valid = 1'b0;
      end else begin
        if (m_mdu_fire) begin void'(p_q.pop_front()); mdu_valid = 1'b0; end
        if (m_iss_fire) p_q.push_back(iss_reg);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      last_rst = !rst_n;
      en = ($urandom_range(0, 7) != 0);
      iss_valid = $urandom_range(0, 1);
      iss_reg = 5'($urandom_range(0, 7));
      if (!mdu_valid && p_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        mdu_valid = 1'b1; mdu_reg = p_q[0]; mdu_data = $urandom;
      end
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_reg = 5'($urandom_range(0, 15));
      if (m_busy[wb_reg]) wb_reg = 5'd0;
      wb_data = $urandom;
      rd_a = 5'($urandom_range(0, 7));
      rd_b = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
